// File: rtl/wave_capture.sv
// Triggered capture buffer: after arming, waits for a rising crossing of trig_level,
// records DEPTH (sample, count) pairs, then replays them over a valid/ready port.
module wave_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] count,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  sample_en,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  arm,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DUMP} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic                   prev_valid_q, prev_valid_d;
  logic [DATA_WIDTH-1:0]  prev_sample_q, prev_sample_d;
  logic                   done_q, done_d;
  logic                   wr_en;
  logic                   trig;

  logic [DATA_WIDTH-1:0]  mem_data_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  mem_addr_q [DEPTH];

  // Rising crossing needs a previous in-ARMED sample strictly below the level.
  assign trig = sample_en && prev_valid_q &&
                (prev_sample_q < trig_level) && (sample >= trig_level);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    prev_valid_d  = prev_valid_q;
    prev_sample_d = prev_sample_q;
    done_d        = 1'b0;
    wr_en         = 1'b0;
    if (abort) begin
      state_d      = IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      prev_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            state_d      = ARMED;
            prev_valid_d = 1'b0;
          end
        end
        ARMED: begin
          if (sample_en) begin
            prev_sample_d = sample;
            prev_valid_d  = 1'b1;
            if (trig) begin
              wr_en    = 1'b1;
              wr_ptr_d = PTR_W'(1);
              state_d  = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (wr_ptr_q == LAST) begin
              state_d  = DUMP;
              rd_ptr_d = '0;
            end
          end
        end
        DUMP: begin
          if (out_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (rd_ptr_q == LAST) begin
              state_d  = IDLE;
              done_d   = 1'b1;
              rd_ptr_d = '0;
              wr_ptr_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      prev_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      prev_valid_q <= prev_valid_d;
      done_q       <= done_d;
    end
  end

  // Datapath storage carries no reset; prev_valid and the state gate its use.
  always_ff @(posedge clk) begin
    prev_sample_q <= prev_sample_d;
    if (wr_en) begin
      mem_data_q[wr_ptr_q] <= sample;
      mem_addr_q[wr_ptr_q] <= count;
    end
  end

  assign out_valid = (state_q == DUMP);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_addr  = out_valid ? mem_addr_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: queue-based capture model compared every cycle, plus
// literal expectations on the played-back sequences.
module tb_wave_capture;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] count = '0;
  logic [DW-1:0] sample = '0;
  logic          sample_en = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          busy;
  logic          done;

  wave_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .count(count), .sample(sample), .sample_en(sample_en),
    .trig_level(trig_level), .arm(arm), .abort(abort), .out_data(out_data),
    .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {int d; int a;} ent_t;

  function automatic ent_t mk(input int d, input int a);
    ent_t e;
    e.d = d;
    e.a = a;
    return e;
  endfunction

  // Model: phase 0 idle, 1 armed, 2 capturing, 3 playing back.
  ent_t cap[$];
  int   m_phase = 0;
  int   m_ps = 0;
  int   m_rd = 0;
  bit   m_pv = 0;
  bit   m_done = 0;
  ent_t log_q[$];
  int   done_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; cap.delete(); m_rd = 0; m_pv = 0; m_done = 0;
    end else begin
      if (out_valid === 1'b1 && out_ready) log_q.push_back(mk(int'(out_data), int'(out_addr)));
      if (done === 1'b1) done_cnt++;
      m_done = 0;
      if (abort) begin
        m_phase = 0; cap.delete(); m_rd = 0; m_pv = 0;
      end else begin
        case (m_phase)
          0: if (arm) begin m_phase = 1; m_pv = 0; end
          1: if (sample_en) begin
               if (m_pv && m_ps < int'(trig_level) && int'(sample) >= int'(trig_level)) begin
                 cap.push_back(mk(int'(sample), int'(count)));
                 m_phase = 2;
               end
               m_ps = int'(sample);
               m_pv = 1;
             end
          2: if (sample_en) begin
               cap.push_back(mk(int'(sample), int'(count)));
               if (cap.size() == DEPTH) begin m_phase = 3; m_rd = 0; end
             end
          default: if (out_ready) begin
               m_rd++;
               if (m_rd == DEPTH) begin
                 m_phase = 0; m_done = 1; cap.delete(); m_rd = 0;
               end
             end
        endcase
      end
    end
    #1;
    chk("busy", busy, int'(m_phase != 0));
    chk("out_valid", out_valid, int'(m_phase == 3));
    chk("done", done, int'(m_done));
    chk("out_data", out_data, (m_phase == 3) ? cap[m_rd].d : 0);
    chk("out_addr", out_addr, (m_phase == 3) ? cap[m_rd].a : 0);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int s, input int c, input bit en);
    sample = DW'(s);
    count = AW'(c);
    sample_en = en;
    tick();
  endtask

  task automatic do_arm(input int lvl);
    trig_level = DW'(lvl);
    sample_en = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic clear_log();
    log_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    sample_en = 1'b0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_reaches_idle"}, busy, 0);
    tick();
  endtask

  // Ramp sample=count from base-16; the crossing lands on base.
  task automatic ramp_run(input string name, input int base);
    clear_log();
    out_ready = 1'b1;
    do_arm(base);
    for (int i = 0; i < 32; i++) drive(base - 16 + i, base - 16 + i, 1'b1);
    wait_idle(name);
    chk({name, "_entries"}, log_q.size(), DEPTH);
    chk({name, "_done_pulses"}, done_cnt, 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i < log_q.size()) begin
        chk({name, "_data"}, log_q[i].d, base + i);
        chk({name, "_addr"}, log_q[i].a, base + i);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_data", out_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Ramp trigger at 0x10
    ramp_run("ramp", 16'h10);

    // No capture without arm; a level already above threshold must not fire
    clear_log();
    out_ready = 1'b1;
    for (int i = 0; i <= 16'h20; i++) drive(i, i, 1'b1);
    chk("unarmed_busy", busy, 0);
    do_arm(16'h10);
    for (int i = 16'h30; i < 16'h40; i++) drive(i, i, 1'b1);
    chk("no_early_trig_busy", busy, 1);
    chk("no_early_trig_valid", out_valid, 0);
    drive(16'h05, 16'h40, 1'b1);
    drive(16'h20, 16'h41, 1'b1);
    for (int i = 1; i < DEPTH; i++) drive(16'h20 + i, 16'h41 + i, 1'b1);
    wait_idle("fresh");
    chk("fresh_entries", log_q.size(), DEPTH);
    if (log_q.size() == DEPTH) begin
      chk("fresh_first_data", log_q[0].d, 16'h20);
      chk("fresh_first_addr", log_q[0].a, 16'h41);
      chk("fresh_last_data", log_q[15].d, 16'h2F);
    end

    // Gapped capture with toggling backpressure
    clear_log();
    do_arm(16'h10);
    drive(16'h0E, 16'h0E, 1'b1);
    drive(16'h0F, 16'h0F, 1'b1);
    drive(16'h10, 16'h10, 1'b1);
    for (int k = 1; k <= 30; k++) drive(16'h10 + k, 16'h10 + k, (k % 2) == 0);
    sample_en = 1'b0;
    for (int j = 0; j < 40; j++) begin
      out_ready = (j % 2) == 1;
      tick();
    end
    out_ready = 1'b1;
    wait_idle("gap");
    chk("gap_entries", log_q.size(), DEPTH);
    chk("gap_done_pulses", done_cnt, 1);
    for (int i = 0; i < DEPTH; i++)
      if (i < log_q.size()) chk("gap_data", log_q[i].d, 16'h10 + 2 * i);

    // Counter address wrap
    clear_log();
    do_arm(16'h80);
    drive(16'h10, 248, 1'b1);
    drive(16'h20, 249, 1'b1);
    drive(16'h90, 250, 1'b1);
    for (int i = 1; i < DEPTH; i++) drive(16'h90 + i, (250 + i) % 256, 1'b1);
    wait_idle("wrap");
    chk("wrap_entries", log_q.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (i < log_q.size()) chk("wrap_addr", log_q[i].a, (250 + i) % 256);

    // Abort on the 5th capture write, then a clean re-arm
    clear_log();
    do_arm(16'h10);
    drive(16'h0E, 0, 1'b1);
    drive(16'h0F, 1, 1'b1);
    drive(16'h10, 2, 1'b1);
    drive(16'h11, 3, 1'b1);
    drive(16'h12, 4, 1'b1);
    drive(16'h13, 5, 1'b1);
    abort = 1'b1;
    drive(16'h14, 6, 1'b1);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    sample_en = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_output", log_q.size(), 0);
    ramp_run("rearm", 16'h10);

    // Asynchronous reset in the middle of playback
    clear_log();
    out_ready = 1'b0;
    do_arm(16'h10);
    for (int i = 0; i < 32; i++) drive(i, i, 1'b1);
    sample_en = 1'b0;
    chk("in_dump", out_valid, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("three_handshakes", log_q.size(), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_data", out_data, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    ramp_run("post_rst", 16'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Triggered capture buffer sitting downstream of the address counter and its waveform ROM in the signal generator.
- Watches the sample stream together with the counter address that produced each sample.
- On a rising level-crossing after being armed, records DEPTH consecutive (sample, address) pairs.
- Then plays the recorded pairs out over a valid/ready interface for display or checking.

Parameters:
- DATA_WIDTH, 8: width of each sample.
- ADDR_WIDTH, 8: width of the counter address. Set equal to the counter's WIDTH at instantiation.
- DEPTH, 16: number of entries captured. Must be a power of 2 and ≥ 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- count  input  ADDR_WIDTH  counter address that produced the current sample.
- sample  input  DATA_WIDTH  ROM output sample (unsigned).
- sample_en  input  1  sample/count are valid this cycle.
- trig_level  input  DATA_WIDTH  trigger threshold (unsigned).
- arm  input  1  request a capture; honoured only in IDLE.
- abort  input  1  cancel any operation.
- out_data  output  DATA_WIDTH  captured sample at the read pointer.
- out_addr  output  ADDR_WIDTH  captured address at the read pointer.
- out_valid  output  1  playback entry available.
- out_ready  input  1  consumer accepts the entry.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse after the final playback handshake.

Behaviour:
- Reset (asynchronous, active-high), from any state including mid-capture or mid-playback:
  - state=IDLE; wr_ptr=0, rd_ptr=0; prev_valid=0.
  - out_valid=0, out_data=0, out_addr=0, busy=0, done=0.
  - Buffer contents are don't-care.
- States: IDLE, ARMED, CAPTURE, DUMP. State is registered; all transitions take effect on the next clk edge.
- abort has priority over every other input in every state:
  - Next state is IDLE; pointers and prev_valid are cleared.
  - done is not pulsed.
  - arm+abort in the same cycle in IDLE leaves the block in IDLE.
- IDLE:
  - arm=1 moves to ARMED and clears prev_valid.
  - sample_en is ignored.
- ARMED:
  - Each sample_en cycle stores sample into prev_sample and sets prev_valid=1.
  - Trigger condition: sample_en && prev_valid && prev_sample < trig_level && sample >= trig_level (unsigned compare).
  - Consequence: at least two sample_en cycles in ARMED are needed before a trigger can fire.
  - On trigger: write {sample, count} to entry 0, wr_ptr becomes 1, next state is CAPTURE.
  - arm while ARMED is ignored.
- CAPTURE:
  - Each sample_en cycle writes {sample, count} to entry wr_ptr and increments wr_ptr.
  - The write to entry DEPTH-1 moves to DUMP and sets rd_ptr=0.
  - Cycles with sample_en=0 write nothing and leave wr_ptr unchanged.
  - Trigger condition and arm are ignored.
- DUMP:
  - out_valid=1; out_data/out_addr come combinationally from entry rd_ptr.
  - Handshake = out_valid && out_ready; rd_ptr increments on each handshake.
  - out_valid holds, with data stable, until a handshake occurs.
  - The handshake on entry DEPTH-1 moves to IDLE; done=1 for exactly the following cycle; rd_ptr and wr_ptr clear.
  - sample_en and arm are ignored.
  - Back-to-back handshakes allowed: one entry per cycle when out_ready is held high.
- Outside DUMP: out_valid=0 and out_data/out_addr are forced to 0.
- busy=1 in ARMED, CAPTURE and DUMP.
- count is stored verbatim; counter wrap-around (e.g. 255→0) is recorded as-is with no special handling.
- Pointers are $clog2(DEPTH) bits and never wrap within a capture.

Test Plan:
- Ramp trigger: arm=1 one cycle, then sample_en=1 every cycle with sample=count=0,1,2,…, trig_level=0x10 → trigger on sample 0x10; out_ready=1 gives 16 entries, data 0x10..0x1F with matching addr; done pulses once the cycle after the 16th handshake.
- No trigger before arm and no early trigger: samples 0x00..0x20 with arm=0 → busy stays 0. Arm while sample is already 0x30 and rising → no trigger until a fresh crossing; first valid sample in ARMED ≥ level never fires.
- Gapped capture and backpressure: sample_en toggling 1/0 during CAPTURE → only enabled samples stored. In DUMP, toggle out_ready 0/1 → out_data stable while out_ready=0; 16 handshakes total.
- Address wrap: count sequence 250..255,0..9 with trig_level=0x80 and samples crossing at count=250 → out_addr sequence 250..255,0..9 exactly.
- Abort mid-capture: abort at the 5th capture write → IDLE next cycle, busy=0, out_valid=0, no done. Re-arm and capture completes normally.
- Async reset mid-DUMP: assert rst between clock edges after 3 handshakes → out_valid/busy drop to 0 immediately; after release, arm+trigger works with rd_ptr starting at entry 0.
